// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage bundle types, their widths and the NOP control word.
// No logic; latency not applicable.
// No handshake; consumers size pipe_stage_reg from these widths.
package pipe_pkg;

    // ID/EX control: everything a bubble must neutralise.
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [1:0] write_src;
        logic       branch;
        logic [3:0] alu_op;
        logic       jump;
        logic       ret;
        logic       mem_write;
    } id_ex_ctrl_t;

    // ID/EX data: operands and indices, never cleared on a bubble.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [5:0]  rsvd;
    } id_ex_data_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] write_src;
        logic       mem_write;
        logic       mem_read;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } ex_mem_data_t;

    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);

    // All-zero control word is a NOP in every stage.
    localparam logic [ID_EX_CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// One payload entry (valid + ctrl + data) with load, clear and flush.
// Latency: load visible on outputs one cycle after the edge.
// No handshake of its own; the parent decides when to load or clear.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              vld_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_vld;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Entry state: ctrl is forced to NOP whenever the entry becomes empty,
    // so an empty entry always presents a bubble; data only moves with a beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld  <= 1'b0;
            r_ctrl <= '0;
            r_data <= '0;
        end else if (flush_i) begin
            r_vld  <= 1'b0;
            r_ctrl <= CTRL_W'(CTRL_NOP);
        end else if (load_i) begin
            r_vld  <= vld_i;
            r_ctrl <= vld_i ? ctrl_i : CTRL_W'(CTRL_NOP);
            if (vld_i) begin
                r_data <= data_i;
            end
        end else if (clr_i) begin
            r_vld  <= 1'b0;
            r_ctrl <= CTRL_W'(CTRL_NOP);
        end
    end

    assign vld_o  = r_vld;
    assign ctrl_o = r_ctrl;
    assign data_o = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register (ctrl + data) with valid/ready, flush, stall counter.
// Latency: 1 cycle from acceptance to out_* when main is empty or draining.
// Backpressure: holds on !out_ready_i; PIPE_STAGE_SKID_EN adds a skid entry so in_ready_o is a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W      = ID_EX_CTRL_W,
    parameter int DATA_W      = ID_EX_DATA_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CTRL_W-1:0]      in_ctrl_i,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [CTRL_W-1:0]      out_ctrl_o,
    output logic [DATA_W-1:0]      out_data_o,
    input  logic                   stall_clr_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    logic              w_main_vld;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_main_en;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Main register may take a new beat when empty or when its beat leaves now.
    assign w_main_en = !w_main_vld || out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic              w_skid_vld;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_acc;

    // Ready comes straight from the skid valid flop: no path from out_ready_i.
    assign in_ready_o = !w_skid_vld;
    assign w_acc      = in_valid_i && !w_skid_vld;

    // Main refills from skid first to keep FIFO order, otherwise from upstream.
    pipe_skid_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .load_i  (w_main_en),
        .clr_i   (1'b0),
        .vld_i   (w_skid_vld || w_acc),
        .ctrl_i  (w_skid_vld ? w_skid_ctrl : in_ctrl_i),
        .data_i  (w_skid_vld ? w_skid_data : in_data_i),
        .vld_o   (w_main_vld),
        .ctrl_o  (w_main_ctrl),
        .data_o  (w_main_data)
    );

    // Skid catches a beat accepted while main is stalled; it empties into main.
    pipe_skid_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .load_i  (w_acc && !w_main_en),
        .clr_i   (w_main_en),
        .vld_i   (1'b1),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .vld_o   (w_skid_vld),
        .ctrl_o  (w_skid_ctrl),
        .data_o  (w_skid_data)
    );
`else
    // Single entry: ready follows the main register's ability to load.
    assign in_ready_o = w_main_en;

    pipe_skid_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .load_i  (w_main_en),
        .clr_i   (1'b0),
        .vld_i   (in_valid_i),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .vld_o   (w_main_vld),
        .ctrl_o  (w_main_ctrl),
        .data_o  (w_main_data)
    );
`endif

    assign out_valid_o = w_main_vld;
    assign out_ctrl_o  = w_main_ctrl;
    assign out_data_o  = w_main_data;

    // Saturating count of cycles a valid beat waited on downstream; clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (stall_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_main_vld && !out_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; works for both skid and non-skid builds.
// Inputs driven 1ns after the rising edge, everything sampled on the falling edge.
// Upstream driver holds a beat until it is accepted or flushed.
module tb_pipe_stage_reg;

    localparam int CW = 12;
    localparam int DW = 120;
    localparam int SW = 4;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [CW-1:0] in_ctrl_i = '0;
    logic [DW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] out_ctrl_o;
    logic [DW-1:0] out_data_o;
    logic          stall_clr_i = 1'b0;
    logic [SW-1:0] stall_cnt_o;

    int      checks = 0;
    int      failures = 0;
    int      n_out = 0;
    int      n0;
    bit      sent = 1'b0;
    logic [SW-1:0] m_cnt = '0;
    beat_t   sb_q[$];
    beat_t   tx_q[$];

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(SW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .stall_clr_i (stall_clr_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d);
        beat_t b;
        b.c = {4'hA, d[7:0]};
        b.d = d;
        return b;
    endfunction

    task automatic present();
        if (tx_q.size() > 0) begin
            in_valid_i = 1'b1;
            in_ctrl_i  = tx_q[0].c;
            in_data_i  = tx_q[0].d;
        end else begin
            in_valid_i = 1'b0;
        end
    endtask

    // One clock: retire the presented beat if it was taken, then present the next.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (sent && tx_q.size() > 0) tx_q.delete(0);
        present();
    endtask

    // Monitor + scoreboard + stall-counter model, all on the falling edge.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_ni) begin
            sb_q.delete();
            sent  = 1'b0;
            m_cnt = '0;
            check_eq("rst_stall_cnt", stall_cnt_o, m_cnt);
        end else begin
            check_eq("stall_cnt", stall_cnt_o, m_cnt);
            if (!out_valid_o) check_eq("bubble_ctrl", out_ctrl_o, 0);
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_out", out_valid_o, 0);
                end else begin
                    b = sb_q.pop_front();
                    check_eq("out_data", out_data_o, b.d);
                    check_eq("out_ctrl", out_ctrl_o, b.c);
                end
                n_out++;
            end
            if (flush_i) begin
                sb_q.delete();
            end else if (in_valid_i && in_ready_o) begin
                b.c = in_ctrl_i;
                b.d = in_data_i;
                sb_q.push_back(b);
            end
            sent = in_valid_i && (in_ready_o || flush_i);
            if (stall_clr_i) m_cnt = '0;
            else if (out_valid_o && !out_ready_i && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: no finish by 50000ns");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid_o, 0);
        check_eq("rst_out_ctrl", out_ctrl_o, 0);
        check_eq("rst_out_data", out_data_o, 0);
        check_eq("rst_cnt", stall_cnt_o, 0);
        repeat (3) cycle();
        rst_ni = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready_o, 1);

        // Continuous stream 0x1..0x8
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) tx_q.push_back(mk(DW'(i)));
        cycle();
        cycle();
        check_eq("lat_valid", out_valid_o, 1);
        check_eq("lat_data", out_data_o, 1);
        n0 = n_out;
        repeat (8) cycle();
        check_eq("stream_no_gaps", n_out - n0, 8);

        // Backpressure: 3 stalled cycles with 0xA, 0xB, 0xC offered
        stall_clr_i = 1'b1;
        out_ready_i = 1'b0;
        tx_q.push_back(mk('hA));
        tx_q.push_back(mk('hB));
        tx_q.push_back(mk('hC));
        n0 = n_out;
        cycle();
        stall_clr_i = 1'b0;
        repeat (4) cycle();
        check_eq("bp_stall_cnt", stall_cnt_o, 3);
        check_eq("bp_in_ready", in_ready_o, 0);
        out_ready_i = 1'b1;
        repeat (6) cycle();
        check_eq("bp_delivered", n_out - n0, 3);
        check_eq("bp_tx_empty", tx_q.size(), 0);

        // Flush with the stage full and 0xD offered in the flush cycle
        out_ready_i = 1'b0;
        tx_q.push_back(mk('h51));
        tx_q.push_back(mk('h52));
        repeat (3) cycle();
        tx_q.delete();
        tx_q.push_back(mk('hD));
        present();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        check_eq("fl_out_valid", out_valid_o, 0);
        check_eq("fl_out_ctrl", out_ctrl_o, 0);
        check_eq("fl_in_ready", in_ready_o, 1);
        out_ready_i = 1'b1;
        n0 = n_out;
        repeat (4) cycle();
        check_eq("fl_nothing_out", n_out - n0, 0);

        // Flush while the held beat is being taken downstream
        tx_q.push_back(mk('h61));
        cycle();
        cycle();
        check_eq("fd_pre_valid", out_valid_o, 1);
        tx_q.push_back(mk('h62));
        present();
        flush_i = 1'b1;
        n0 = n_out;
        cycle();
        flush_i = 1'b0;
        check_eq("fd_transferred", n_out - n0, 1);
        check_eq("fd_empty_after", out_valid_o, 0);
        repeat (3) cycle();
        check_eq("fd_no_more", n_out - n0, 1);

        // Counter saturation and clear-over-stall
        stall_clr_i = 1'b1;
        out_ready_i = 1'b0;
        tx_q.push_back(mk('h71));
        cycle();
        stall_clr_i = 1'b0;
        cycle();
        repeat (20) cycle();
        check_eq("sat_cnt", stall_cnt_o, 15);
        stall_clr_i = 1'b1;
        cycle();
        stall_clr_i = 1'b0;
        check_eq("clr_over_stall", stall_cnt_o, 0);
        out_ready_i = 1'b1;
        repeat (3) cycle();

        // Reset dropped mid-stream with a stalled valid beat
        out_ready_i = 1'b0;
        tx_q.push_back(mk('h81));
        tx_q.push_back(mk('h82));
        repeat (4) cycle();
        check_eq("mr_pre_valid", out_valid_o, 1);
        tx_q.delete();
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_eq("mr_out_valid", out_valid_o, 0);
        check_eq("mr_out_ctrl", out_ctrl_o, 0);
        check_eq("mr_cnt", stall_cnt_o, 0);
        repeat (2) cycle();
        rst_ni = 1'b1;
        #1;
        check_eq("mr_in_ready", in_ready_o, 1);

        // Short stream after reset
        out_ready_i = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 3; i++) tx_q.push_back(mk(DW'('h91 + i)));
        repeat (6) cycle();
        check_eq("post_rst_stream", n_out - n0, 3);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
